// File: rtl/int_claim_pkg.sv
// Shared constants for the claim/complete interrupt dispatcher: register
// word addresses, priority nibble layout and the "nothing to claim" code.
package int_claim_pkg;

    // Register word addresses
    localparam int CTRL      = 0;
    localparam int IER       = 1;
    localparam int EDGE      = 2;
    localparam int IPR       = 3;
    localparam int ISR       = 4;
    localparam int THRESH    = 5;
    localparam int CLAIM     = 6;
    localparam int PRIO_BASE = 8;

    // Priority layout: one nibble per source, eight nibbles per 32-bit word
    localparam int NIBBLE_W         = 4;
    localparam int NIBBLES_PER_WORD = 8;
    localparam int PRIO_WORD_W      = NIBBLE_W * NIBBLES_PER_WORD;
    localparam int PRIO_WORDS       = 4;

    // Value returned by a CLAIM read when nothing is eligible
    localparam int CLAIM_NONE = 0;

    // Width of a source index; a single-source build still needs one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_prio_sel.sv
// Combinational winner selection: highest priority among the eligible
// sources, ties resolved towards the lowest source index.
module int_prio_sel #(
    parameter int INT_NUM = 8,
    parameter int PRIw    = 3,
    parameter int ID_W    = 3
) (
    input  logic [INT_NUM-1:0]      elig,
    input  logic [INT_NUM*PRIw-1:0] prio_flat,
    output logic                    valid,
    output logic [ID_W-1:0]         id
);

    logic [PRIw-1:0] best_prio;

    // Linear scan; a strictly greater priority is needed to displace an
    // earlier winner, which is what gives the lowest index the tie.
    always_comb begin
        valid     = 1'b0;
        id        = '0;
        best_prio = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            if (elig[i] && (!valid || (prio_flat[i*PRIw +: PRIw] > best_prio))) begin
                valid     = 1'b1;
                id        = ID_W'(i);
                best_prio = prio_flat[i*PRIw +: PRIw];
            end
        end
    end

endmodule

// File: rtl/int_claim_ctrl.sv
// Prioritised claim/complete interrupt dispatcher with a Wishbone slave
// register port. Sources are latched into IPR, claimed into ISR through the
// CLAIM register and released by writing their ID to COMPLETE.
module int_claim_ctrl
    import int_claim_pkg::*;
#(
    parameter int INT_NUM = 8,
    parameter int PRIw    = 3,
    parameter int Dw      = 32,
    parameter int Aw      = 4,
    parameter int SELw    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [Dw-1:0]      sa_dat_i,
    input  logic [SELw-1:0]    sa_sel_i,
    input  logic [Aw-1:0]      sa_addr_i,
    input  logic               sa_stb_i,
    input  logic               sa_we_i,
    output logic [Dw-1:0]      sa_dat_o,
    output logic               sa_ack_o,
    output logic               sa_err_o,
    output logic               sa_rty_o,
    input  logic [INT_NUM-1:0] int_i,
    output logic               int_o
);

    localparam int ID_W = id_width(INT_NUM);

    // Architectural state
    logic               gen_reg;
    logic [INT_NUM-1:0] ier_reg;
    logic [INT_NUM-1:0] edge_reg;
    logic [INT_NUM-1:0] ipr_reg;
    logic [INT_NUM-1:0] isr_reg;
    logic [INT_NUM-1:0] int_d_reg;
    logic [PRIw-1:0]    thresh_reg;
    logic [PRIw-1:0]    prio_reg [INT_NUM];
    logic               best_valid_reg;
    logic [ID_W-1:0]    best_id_reg;
    logic               ack_reg;
    logic [Dw-1:0]      dat_reg;
    logic               int_reg;

    // Bus decode
    logic accept;
    logic wr_acc;
    logic rd_acc;
    logic claim_take;
    logic complete_hit;

    // Per-source vectors
    logic [INT_NUM-1:0]      claim_vec;
    logic [INT_NUM-1:0]      complete_vec;
    logic [INT_NUM-1:0]      set_vec;
    logic [INT_NUM-1:0]      elig;
    logic [INT_NUM*PRIw-1:0] prio_flat;

    logic [PRIO_WORDS*PRIO_WORD_W-1:0] prio_all;
    logic [Dw-1:0]                     rd_data;

    logic            sel_valid;
    logic [ID_W-1:0] sel_id;

    // Byte selects carry no information: every access is a full word.
    logic unused_sel;
    assign unused_sel = ^sa_sel_i;

    // A transaction is taken in the single cycle where stb is high and ack
    // is not yet out, so every side effect happens exactly once.
    assign accept       = sa_stb_i && !ack_reg;
    assign wr_acc       = accept && sa_we_i;
    assign rd_acc       = accept && !sa_we_i;
    assign claim_take   = rd_acc && (sa_addr_i == Aw'(CLAIM)) && best_valid_reg;
    assign complete_hit = wr_acc && (sa_addr_i == Aw'(CLAIM));

    generate
        for (genvar gi = 0; gi < INT_NUM; gi++) begin : g_src
            assign claim_vec[gi] = claim_take && (best_id_reg == ID_W'(gi));
            // Only IDs 1..INT_NUM can ever match, so out-of-range writes fall through.
            assign complete_vec[gi] = complete_hit && (sa_dat_i == Dw'(gi + 1));
            // A level source being claimed this cycle counts as in service already,
            // so it drops out of IPR until COMPLETE; an edge still wins over the clear.
            assign set_vec[gi] = edge_reg[gi] ? (int_i[gi] & ~int_d_reg[gi])
                                              : (int_i[gi] & ~(isr_reg[gi] | claim_vec[gi]));
            assign elig[gi] = ipr_reg[gi] & ier_reg[gi] & ~isr_reg[gi]
                              & (prio_reg[gi] > thresh_reg);
            assign prio_flat[gi*PRIw +: PRIw] = prio_reg[gi];
        end

        // Readback image of all priority words; absent sources read as zero.
        for (genvar gi = 0; gi < PRIO_WORDS*NIBBLES_PER_WORD; gi++) begin : g_nib
            if (gi < INT_NUM) begin : g_used
                assign prio_all[gi*NIBBLE_W +: NIBBLE_W] = NIBBLE_W'(prio_reg[gi]);
            end else begin : g_empty
                assign prio_all[gi*NIBBLE_W +: NIBBLE_W] = '0;
            end
        end
    endgenerate

    int_prio_sel #(
        .INT_NUM (INT_NUM),
        .PRIw    (PRIw),
        .ID_W    (ID_W)
    ) u_sel (
        .elig      (elig),
        .prio_flat (prio_flat),
        .valid     (sel_valid),
        .id        (sel_id)
    );

    // Read multiplexer; CLAIM reports the registered winner as ID+1.
    always_comb begin
        rd_data = '0;
        case (sa_addr_i)
            Aw'(CTRL):   rd_data = Dw'(gen_reg);
            Aw'(IER):    rd_data = Dw'(ier_reg);
            Aw'(EDGE):   rd_data = Dw'(edge_reg);
            Aw'(IPR):    rd_data = Dw'(ipr_reg);
            Aw'(ISR):    rd_data = Dw'(isr_reg);
            Aw'(THRESH): rd_data = Dw'(thresh_reg);
            Aw'(CLAIM):  rd_data = best_valid_reg ? (Dw'(best_id_reg) + Dw'(1)) : Dw'(CLAIM_NONE);
            default:     rd_data = '0;
        endcase
        for (int w = 0; w < PRIO_WORDS; w++) begin
            if (sa_addr_i == Aw'(PRIO_BASE + w)) begin
                rd_data = Dw'(prio_all[w*PRIO_WORD_W +: PRIO_WORD_W]);
            end
        end
    end

    // Handshake: ack every accepted transaction, capture read data with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_reg <= 1'b0;
            dat_reg <= '0;
        end else begin
            ack_reg <= accept;
            if (accept) begin
                dat_reg <= rd_data;
            end
        end
    end

    // Software-writable control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            gen_reg    <= 1'b0;
            ier_reg    <= '0;
            edge_reg   <= '0;
            thresh_reg <= '0;
        end else if (wr_acc) begin
            case (sa_addr_i)
                Aw'(CTRL):   gen_reg    <= sa_dat_i[0];
                Aw'(IER):    ier_reg    <= sa_dat_i[INT_NUM-1:0];
                Aw'(EDGE):   edge_reg   <= sa_dat_i[INT_NUM-1:0];
                Aw'(THRESH): thresh_reg <= sa_dat_i[PRIw-1:0];
                default: ;
            endcase
        end
    end

    // Per-source priorities, written a word of nibbles at a time.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < INT_NUM; i++) begin
                prio_reg[i] <= '0;
            end
        end else if (wr_acc) begin
            for (int i = 0; i < INT_NUM; i++) begin
                if (sa_addr_i == Aw'(PRIO_BASE + i / NIBBLES_PER_WORD)) begin
                    prio_reg[i] <= sa_dat_i[NIBBLE_W*(i % NIBBLES_PER_WORD) +: PRIw];
                end
            end
        end
    end

    // Pending and in-service tracking; a claim and a complete never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_d_reg <= '0;
            ipr_reg   <= '0;
            isr_reg   <= '0;
        end else begin
            int_d_reg <= int_i;
            ipr_reg   <= (ipr_reg & ~claim_vec) | set_vec;
            isr_reg   <= (isr_reg | claim_vec) & ~complete_vec;
        end
    end

    // Register the winner, then the CPU line one cycle behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_valid_reg <= 1'b0;
            best_id_reg    <= '0;
            int_reg        <= 1'b0;
        end else begin
            best_valid_reg <= sel_valid;
            best_id_reg    <= sel_id;
            int_reg        <= gen_reg & best_valid_reg;
        end
    end

    assign sa_dat_o = dat_reg;
    assign sa_ack_o = ack_reg;
    assign sa_err_o = 1'b0;
    assign sa_rty_o = 1'b0;
    assign int_o    = int_reg;

endmodule

// File: tb/tb_int_claim_ctrl.sv
// Bench for int_claim_ctrl: directed walkthrough with literal expectations,
// then randomized bus and source traffic checked every cycle against a
// behavioural model of the dispatcher.
module tb_int_claim_ctrl;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sa_dat_i;
    logic [3:0]  sa_sel_i;
    logic [3:0]  sa_addr_i;
    logic        sa_stb_i;
    logic        sa_we_i;
    logic [31:0] sa_dat_o;
    logic        sa_ack_o;
    logic        sa_err_o;
    logic        sa_rty_o;
    logic [N-1:0] int_i;
    logic        int_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    int_claim_ctrl #(.INT_NUM(N), .PRIw(3), .Dw(32), .Aw(4), .SELw(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .sa_dat_i  (sa_dat_i),
        .sa_sel_i  (sa_sel_i),
        .sa_addr_i (sa_addr_i),
        .sa_stb_i  (sa_stb_i),
        .sa_we_i   (sa_we_i),
        .sa_dat_o  (sa_dat_o),
        .sa_ack_o  (sa_ack_o),
        .sa_err_o  (sa_err_o),
        .sa_rty_o  (sa_rty_o),
        .int_i     (int_i),
        .int_o     (int_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_gen;
    bit [7:0]  m_ier, m_edge, m_ipr, m_isr, m_prev;
    int        m_thresh;
    int        m_prio [N];
    bit        m_bv;
    int        m_bid;
    bit        m_ack, m_rdack, m_int;
    bit [31:0] m_dat;

    // Most urgent eligible source: walk priority levels from the top, first index wins.
    function automatic int winner();
        for (int p = 7; p >= 1; p--)
            for (int i = 0; i < N; i++)
                if (m_ipr[i] && m_ier[i] && !m_isr[i] && m_prio[i] > m_thresh && m_prio[i] == p)
                    return i;
        return -1;
    endfunction

    function automatic bit [31:0] model_read(input int a);
        bit [31:0] w;
        w = 0;
        case (a)
            0: w = {31'b0, m_gen};
            1: w = 32'(m_ier);
            2: w = 32'(m_edge);
            3: w = 32'(m_ipr);
            4: w = 32'(m_isr);
            5: w = 32'(m_thresh);
            8: for (int i = 0; i < N; i++) w = w | (32'(m_prio[i]) << (4*i));
            default: w = 0;
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        int win, a, d;
        bit acc;
        bit [7:0] clr, setv;
        bit [31:0] rd;
        if (reset) begin
            m_gen = 0; m_ier = 0; m_edge = 0; m_ipr = 0; m_isr = 0; m_prev = 0;
            m_thresh = 0; m_bv = 0; m_bid = 0; m_ack = 0; m_rdack = 0; m_int = 0; m_dat = 0;
            for (int i = 0; i < N; i++) m_prio[i] = 0;
        end else begin
            acc = sa_stb_i && !m_ack;
            a   = int'(sa_addr_i);
            win = winner();
            clr = 0;
            rd  = m_dat;
            if (acc && !sa_we_i) begin
                if (a == 6) begin
                    if (m_bv) begin
                        rd = 32'(m_bid + 1);
                        clr[m_bid] = 1'b1;
                    end else begin
                        rd = 0;
                    end
                end else begin
                    rd = model_read(a);
                end
            end
            for (int i = 0; i < N; i++)
                setv[i] = m_edge[i] ? (int_i[i] && !m_prev[i]) : (int_i[i] && !m_isr[i] && !clr[i]);
            m_ipr = (m_ipr & ~clr) | setv;
            m_isr = m_isr | clr;
            m_int = m_gen && m_bv;
            if (acc && sa_we_i) begin
                case (a)
                    0: m_gen = sa_dat_i[0];
                    1: m_ier = sa_dat_i[7:0];
                    2: m_edge = sa_dat_i[7:0];
                    5: m_thresh = int'(sa_dat_i[2:0]);
                    6: if (sa_dat_i >= 32'd1 && sa_dat_i <= 32'd8) begin
                           d = int'(sa_dat_i);
                           m_isr[d-1] = 1'b0;
                       end
                    8: for (int i = 0; i < N; i++) m_prio[i] = int'((sa_dat_i >> (4*i)) & 32'h7);
                    default: ;
                endcase
            end
            m_bv    = (win >= 0);
            m_bid   = (win >= 0) ? win : 0;
            m_rdack = acc && !sa_we_i;
            m_ack   = acc;
            if (acc) m_dat = rd;
            m_prev  = int_i;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("ack", {31'b0, sa_ack_o}, {31'b0, m_ack});
            check("int_o", {31'b0, int_o}, {31'b0, m_int});
            check("err_rty", {30'b0, sa_err_o, sa_rty_o}, 32'd0);
            if (m_rdack) check("rdata", sa_dat_o, m_dat);
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_go(input bit we, input int addr, input bit [31:0] wd, output bit [31:0] rd);
        bit done;
        done = 1'b0;
        rd = 0;
        sa_stb_i = 1'b1; sa_we_i = we; sa_addr_i = 4'(addr); sa_dat_i = wd;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (sa_ack_o) begin
                rd = sa_dat_o;
                done = 1'b1;
            end
        end
        if (!done) check("bus_ack_timeout", {31'b0, sa_ack_o}, 32'd1);
        sa_stb_i = 1'b0; sa_we_i = 1'b0;
    endtask

    task automatic bus_txn(input bit we, input int addr, input bit [31:0] wd, output bit [31:0] rd);
        @(negedge clk);
        bus_go(we, addr, wd, rd);
    endtask

    task automatic wr(input int addr, input bit [31:0] wd);
        bit [31:0] rd;
        bus_txn(1'b1, addr, wd, rd);
    endtask

    task automatic rd_chk(input string name, input int addr, input bit [31:0] exp);
        bit [31:0] rd;
        bus_txn(1'b0, addr, 32'd0, rd);
        check(name, rd, exp);
        $display("read  addr %0d -> 0x%0h (expect 0x%0h) %s", addr, rd, exp, name);
    endtask

    task automatic pulse(input bit [7:0] v);
        @(negedge clk); int_i = v;
        @(negedge clk); int_i = 8'h00;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit [31:0] rd;
        reset = 1'b1; sa_stb_i = 1'b0; sa_we_i = 1'b0; sa_addr_i = 4'd0;
        sa_dat_i = 32'd0; sa_sel_i = 4'hF; int_i = 8'h00;
        repeat (3) @(negedge clk);
        started = 1'b1;
        reset = 1'b0;
        check("rst_ack", {31'b0, sa_ack_o}, 32'd0);
        check("rst_int", {31'b0, int_o}, 32'd0);
        for (int a = 0; a < 16; a++) rd_chk($sformatf("rst_reg%0d", a), a, 32'd0);

        // Two edge sources at different priorities
        wr(0, 32'd1); wr(1, 32'h0F); wr(2, 32'hFE); wr(5, 32'd0); wr(8, 32'h0000_5020);
        pulse(8'h0A);
        cycles(3);
        check("int_on", {31'b0, int_o}, 32'd1);
        rd_chk("claim_p5", 6, 32'd4);
        rd_chk("claim_p2", 6, 32'd2);
        rd_chk("claim_none", 6, 32'd0);
        rd_chk("isr_0a", 4, 32'h0A);

        // Equal priorities go to the lower index
        wr(8, 32'h0030_5320); wr(1, 32'h2F);
        pulse(8'h24);
        cycles(3);
        rd_chk("claim_tie", 6, 32'd3);
        wr(6, 32'd3);
        rd_chk("isr_after_c3", 4, 32'h0A);
        wr(6, 32'd2); wr(6, 32'd4);
        rd_chk("claim_src5", 6, 32'd6);
        wr(6, 32'd6);
        rd_chk("isr_clear", 4, 32'h00);

        // Level source 0 held high
        wr(8, 32'h0030_5321);
        @(negedge clk); int_i = 8'h01;
        cycles(3);
        check("int_level", {31'b0, int_o}, 32'd1);
        rd_chk("claim_lvl", 6, 32'd1);
        rd_chk("ipr_lvl_insvc", 3, 32'h00);
        wr(6, 32'd1);
        rd_chk("ipr_lvl_repend", 3, 32'h01);
        cycles(2);
        check("int_lvl_again", {31'b0, int_o}, 32'd1);
        @(negedge clk); int_i = 8'h00;
        rd_chk("claim_lvl2", 6, 32'd1);
        wr(6, 32'd1);
        rd_chk("ipr_lvl_gone", 3, 32'h00);

        // Threshold gating
        wr(5, 32'd4);
        pulse(8'h04);
        cycles(3);
        check("int_thresh_off", {31'b0, int_o}, 32'd0);
        rd_chk("claim_thresh", 6, 32'd0);
        wr(5, 32'd2);
        cycles(2);
        check("int_thresh_on", {31'b0, int_o}, 32'd1);
        rd_chk("claim_after_thr", 6, 32'd3);
        wr(6, 32'd3); wr(5, 32'd0);

        // New edge in the same cycle as the claim of that source
        pulse(8'h02);
        @(negedge clk); int_i = 8'h02;
        bus_go(1'b0, 6, 32'd0, rd);
        check("claim_edge_race", rd, 32'd2);
        rd_chk("ipr_edge_kept", 3, 32'h02);
        wr(6, 32'h21);
        rd_chk("isr_bad_complete", 4, 32'h02);
        @(negedge clk); int_i = 8'h00;
        wr(6, 32'd2);
        rd_chk("claim_reedge", 6, 32'd2);
        wr(6, 32'd2);
        rd_chk("isr_end", 4, 32'h00);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 399) == 0);
            sa_stb_i  = ($urandom_range(0, 2) != 0);
            sa_we_i   = $urandom_range(0, 1) == 1;
            sa_addr_i = ($urandom_range(0, 9) < 3) ? 4'd6 : 4'($urandom_range(0, 15));
            sa_dat_i  = (sa_addr_i == 4'd6) ? 32'($urandom_range(0, 10)) : $urandom;
            if ($urandom_range(0, 3) == 0) int_i = 8'($urandom & $urandom);
        end
        @(negedge clk);
        reset = 1'b0; sa_stb_i = 1'b0; sa_we_i = 1'b0; int_i = 8'h00;
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
